// File: rtl/serial_adder.sv
// Bit-serial adder: one result bit per clock, LSB first, WIDTH cycles per operation.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, acc, acc_nxt;
  logic             c_r, bit_s, carry_nxt, last;
  logic [CW-1:0]    cnt;

  assign bit_s     = a_r[cnt] ^ b_r[cnt] ^ c_r;
  assign carry_nxt = (a_r[cnt] & b_r[cnt]) | (a_r[cnt] & c_r) | (b_r[cnt] & c_r);
  assign last      = (cnt == CW'(WIDTH - 1));
  assign busy      = (state == ADD);
  assign done      = (state == DONE);

  // Partial result with the current bit merged in; on the last bit this is the full sum.
  always_comb begin
    acc_nxt      = acc;
    acc_nxt[cnt] = bit_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? ADD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      c_r  <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      sum  <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        ADD: begin
          c_r <= carry_nxt;
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            sum  <= acc_nxt;
            cout <= carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
            // c_r here is the carry into the MSB
            ovf  <= c_r ^ carry_nxt;
`endif
          end
        end
        default: begin
          if (start) begin
            a_r <= a;
            b_r <= b;
            c_r <= cin;
            cnt <= '0;
            acc <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk, rst, start, cin;
  logic [WIDTH-1:0] a, b, sum;
  logic             busy, done, cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; leaves at the negedge just after the start edge.
  task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
  endtask

  // Waits for done and checks latency, busy duration, output stability and result.
  task automatic wait_result(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                             input logic cv, input bit inject);
    int unsigned  full;
    int           s_signed;
    int           n = 0;
    int           busy_n = 0;
    bit           stable = 1'b1;
    logic [WIDTH-1:0] s0 = sum;
    logic         c0 = cout;
    full     = int'(av) + int'(bv) + int'(cv);
    s_signed = int'($signed(av)) + int'($signed(bv)) + int'(cv);
    while (!done && n < 20) begin
      if (busy) busy_n++;
      if (sum !== s0 || cout !== c0) stable = 1'b0;
      if (inject && n == 2) begin start = 1'b1; a = 8'h01; b = 8'h01; end
      if (inject && n == 3) start = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(WIDTH));
    check({tag, ".busy_cycles"}, 64'(busy_n), 64'(WIDTH));
    check({tag, ".stable_in_add"}, 64'(stable), 64'd1);
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    check({tag, ".sum"}, 64'(sum), 64'(full % 256));
    check({tag, ".cout"}, 64'(cout), 64'(full / 256));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, ".ovf"}, 64'(ovf), 64'((s_signed > 127) || (s_signed < -128)));
`else
    if (s_signed > 1000) $display("unexpected model value");
`endif
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, ".done_pulse_end"}, 64'(done), 64'd0);
    check({tag, ".idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rc;
    int               done_seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.sum", 64'(sum), 64'd0);
    check("reset.cout", 64'(cout), 64'd0);
    rst = 1'b0;

    launch(8'h12, 8'h34, 1'b1);
    wait_result("add_12_34", 8'h12, 8'h34, 1'b1, 1'b0);
    idle_check("add_12_34");

    launch(8'hFF, 8'h01, 1'b0);
    wait_result("wrap_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    idle_check("wrap_ff_01");

    launch(8'h7F, 8'h01, 1'b0);
    wait_result("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0);
    idle_check("ovf_7f_01");

    launch(8'h10, 8'h20, 1'b0);
    wait_result("ignore_start", 8'h10, 8'h20, 1'b0, 1'b1);
    idle_check("ignore_start");
    @(negedge clk);
    check("ignore_start.no_second_done", 64'(done), 64'd0);

    // Reset partway through an addition; sum currently holds 8'h30.
    launch(8'h33, 8'h44, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.done", 64'(done), 64'd0);
    check("rst_mid.sum", 64'(sum), 64'd0);
    check("rst_mid.cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_mid.ovf", 64'(ovf), 64'd0);
`endif
    start = 1'b1; a = 8'h11; b = 8'h22;
    @(negedge clk);
    check("rst_mid.start_ignored", 64'(busy), 64'd0);
    start = 1'b0; rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("rst_mid.no_activity", 64'(done_seen), 64'd0);
    launch(8'hA5, 8'h5A, 1'b0);
    wait_result("after_rst", 8'hA5, 8'h5A, 1'b0, 1'b0);

    // Back-to-back: start held in the DONE cycle.
    launch(8'h80, 8'h80, 1'b0);
    check("b2b.reentry_busy", 64'(busy), 64'd1);
    wait_result("b2b", 8'h80, 8'h80, 1'b0, 1'b0);
    idle_check("b2b");

    for (int k = 0; k < 40; k++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
      launch(ra, rb, rc);
      wait_result("rand", ra, rb, rc, 1'b0);
      if ($urandom_range(0, 1) == 0) idle_check("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal range 1..64).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: start  input  1  request to begin an addition, sampled on clk.
REQ-005 SHALL have port: a  input  WIDTH  first operand, unsigned/two's complement.
REQ-006 SHALL have port: b  input  WIDTH  second operand.
REQ-007 SHALL have port: cin  input  1  carry-in for bit 0.
REQ-008 SHALL have port: busy  output  1  high while bits are being computed.
REQ-009 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port: sum  output  WIDTH  registered result.
REQ-011 SHALL have port: cout  output  1  registered carry-out of MSB.

Function
REQ-012 SHALL implement an FSM with states IDLE, ADD, DONE; reset state IDLE.
REQ-013 SHALL, in IDLE or DONE with start=1 at edge E0, latch a, b, cin into internal registers, clear bit counter, enter ADD.
REQ-014 SHALL, in ADD, compute one result bit per edge, LSB first: bit = a_i ^ b_i ^ c; c <= majority(a_i, b_i, c).
REQ-015 SHALL complete bit WIDTH-1 at edge E0+WIDTH, load sum/cout output registers at that edge, and enter DONE.
REQ-016 SHALL assert done for exactly the cycle following edge E0+WIDTH; latency start-to-done = WIDTH cycles.
REQ-017 SHALL assert busy exactly while in ADD; busy=0 in IDLE and DONE.
REQ-018 SHALL leave DONE for IDLE on the next edge unless start=1, which SHALL begin a new operation (back-to-back, no bubble).
REQ-019 SHALL ignore start while in ADD; operand/cin changes during ADD SHALL not affect the result.
REQ-020 SHALL hold sum/cout stable from the DONE load until the next completed operation; they SHALL not toggle during ADD.
REQ-021 SHALL produce wrap-around results modulo 2^WIDTH with the lost bit on cout (e.g. all-ones + 1 -> sum 0, cout 1).
REQ-022 SHALL operate correctly for WIDTH=1 (single ADD cycle).

Reset
REQ-023 SHALL, on rst high, immediately (without clk) force state IDLE, busy=0, done=0, sum=0, cout=0, internal carry/counter/operand registers 0.
REQ-024 SHALL abort an in-progress operation on reset; no partial result SHALL appear on sum/cout.
REQ-025 SHALL ignore start while rst is high; first start is accepted on the first edge after rst deasserts.

Configuration
REQ-026 SHALL, when macro SERIAL_ADDER_OVF_EN is defined, add port ovf  output  1, registered with sum, = carry into MSB XOR cout (signed overflow), reset value 0.
REQ-027 SHALL, when SERIAL_ADDER_OVF_EN is undefined, have no ovf port and no overflow logic; all other behaviour identical.

Verification (WIDTH=8)
REQ-028 SHALL cover: a=8'h12, b=8'h34, cin=1, start pulse -> busy 8 cycles, done pulse 8 cycles after start, sum=8'h47, cout=0.
REQ-029 SHALL cover: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0 (if enabled).
REQ-030 SHALL cover: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1 (if enabled).
REQ-031 SHALL cover: start=1 with a=8'h01,b=8'h01 during ADD of 8'h10+8'h20 -> ignored, result 8'h30, single done pulse.
REQ-032 SHALL cover: rst pulsed mid-ADD (4th bit) -> busy/done/sum/cout 0 immediately, no done; next start 8'hA5+8'h5A cin0 -> sum=8'hFF, cout=0.
REQ-033 SHALL cover: start held high in DONE cycle with new operands 8'h80+8'h80 -> immediate re-entry to ADD, next result sum=8'h00, cout=1.
